sys_cmd_ctrl: RTL and testbench
===============================

// Module: sys_cmd_ctrl
// PURPOSE
//  Command decoder/sequencer downstream of the RX-side bus synchronizer.
//  Consumes synchronized RX bytes (data + 1-cycle valid pulse) and executes framed commands:
//  register-file write/read, and ALU ops with or without new operands.
//  Returns results as bytes to the TX FIFO write port, honouring a full flag. Runs in the REF clock domain.
// PARAMETERS
//  DATA_WIDTH  8  byte width of RX/TX/register-file data
//  ADDR_WIDTH  4  register-file address width
//  FUN_WIDTH   4  ALU function-code width (low bits of function byte)
// PORTS
//  clk            in   1     system (REF) clock
//  rst            in   1     asynchronous, active-low reset
//  rx_data        in   DW    synchronized RX byte; valid only when rx_valid=1
//  rx_valid       in   1     single-cycle pulse, one per received byte
//  rf_wr_en       out  1     register-file write strobe (1 cycle)
//  rf_rd_en       out  1     register-file read strobe (1 cycle)
//  rf_addr        out  AW    register-file address
//  rf_wr_data     out  DW    register-file write data
//  rf_rd_data     in   DW    register-file read data
//  rf_rd_valid    in   1     read data valid pulse
//  alu_en         out  1     ALU start strobe (1 cycle)
//  alu_fun        out  FW    ALU function code
//  alu_out        in   2*DW  ALU result
//  alu_out_valid  in   1     ALU result valid pulse
//  clk_gate_en    out  1     ALU clock-gate enable
//  tx_data        out  DW    byte to TX FIFO
//  tx_valid       out  1     TX FIFO write strobe (1 cycle)
//  fifo_full      in   1     TX FIFO full; no tx_valid while high
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs 0; internal operand/result registers 0.
//    Reset mid-command aborts it; no partial strobes afterwards.
//  - All outputs registered. Strobes assert the cycle after the enabling rx_valid/input pulse.
//  - Opcodes (first byte in IDLE):
//    0xAA write: addr, data
//    0xBB read: addr
//    0xCC ALU with operands: A, B, fun
//    0xDD ALU no operands: fun
//    Any other opcode is ignored; stay in IDLE.
//  - Bytes are consumed only in states awaiting a byte. rx_valid in RD_WAIT/ALU_WAIT/SEND_* is dropped.
//  - Address byte: rf_addr <= rx_data[AW-1:0]; upper bits ignored.
//  - FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI.
//    - WR_ADDR -> WR_DATA on byte. WR_DATA: on byte, rf_wr_en=1, rf_wr_data=byte -> IDLE.
//    - RD_ADDR: on byte, rf_rd_en=1 -> RD_WAIT. RD_WAIT: on rf_rd_valid capture rf_rd_data -> SEND_HI,
//      which sends that single byte.
//    - OP_A: on byte, write addr 0 -> OP_B. OP_B: on byte, write addr 1 -> ALU_FUN.
//    - ALU_FUN: on byte, alu_fun=byte[FW-1:0], alu_en=1 -> ALU_WAIT.
//    - ALU_WAIT: on alu_out_valid capture alu_out -> SEND_LO.
//    - SEND_LO: low byte, then SEND_HI: high byte, then IDLE.
//  - clk_gate_en=1 in ALU_FUN and ALU_WAIT, and in OP_A/OP_B for 0xCC; 0 elsewhere.
//  - TX handshake:
//    - In a SEND state, tx_valid=1 for exactly 1 cycle when fifo_full=0, then advance.
//    - If fifo_full=1, hold the state and tx_data until it clears. Never write while full.
//  - No timeout. RD_WAIT/ALU_WAIT wait indefinitely for their valid pulse; only reset exits.
//  - Back-to-back commands: an rx_valid arriving on the cycle IDLE is re-entered is decoded as a new opcode.
// TESTING
//  1. AA,05,3C -> one rf_wr_en pulse with rf_addr=5, rf_wr_data=0x3C; back to IDLE, no tx_valid.
//  2. BB,02; rf returns 0x7E -> rf_rd_en with addr 2; single tx_valid with tx_data=0x7E.
//  3. CC,10,20,00; alu_out=0x0030 -> writes addr0=0x10, addr1=0x20; alu_en with fun=0;
//     tx 0x30 then 0x00; clk_gate_en high only during ALU phase.
//  4. DD,01 with fifo_full=1 for 5 cycles after alu_out_valid -> no tx_valid while full;
//     LO then HI bytes sent after release, each exactly once.
//  5. Opcode 0x55, then AA,01,FF -> 0x55 ignored; write to addr1=0xFF executes normally.
//  6. rst pulsed low while in ALU_WAIT -> all outputs 0, IDLE; a late alu_out_valid produces no tx.

Source files
------------

// File: rtl/sys_cmd_ctrl.sv
// Command decoder/sequencer: turns framed RX bytes into register-file and ALU
// operations and streams results back to the TX FIFO.
module sys_cmd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rf_wr_en,
    output logic                      rf_rd_en,
    output logic [ADDR_WIDTH-1:0]     rf_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data,
    input  logic [DATA_WIDTH-1:0]     rf_rd_data,
    input  logic                      rf_rd_valid,
    output logic                      alu_en,
    output logic [FUN_WIDTH-1:0]      alu_fun,
    input  logic [2*DATA_WIDTH-1:0]   alu_out,
    input  logic                      alu_out_valid,
    output logic                      clk_gate_en,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      fifo_full
);

    localparam logic [DATA_WIDTH-1:0] OP_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] OP_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] OP_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] OP_ALUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_WAIT, S_SEND_LO, S_SEND_HI
    } state_t;

    state_t                    state_q, state_d;
    logic                      rf_wr_en_q, rf_wr_en_d;
    logic                      rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0]     rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]     rf_wr_data_q, rf_wr_data_d;
    logic                      alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]      alu_fun_q, alu_fun_d;
    logic                      cg_q, cg_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      tx_valid_q, tx_valid_d;
    logic [2*DATA_WIDTH-1:0]   res_q, res_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            cg_q         <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            cg_q         <= cg_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            res_q        <= res_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        res_d        = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_WR:   state_d = S_WR_ADDR;
                        OP_RD:   state_d = S_RD_ADDR;
                        OP_ALU:  state_d = S_OP_A;
                        OP_ALUN: state_d = S_ALU_FUN;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d = rx_data[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (rx_valid) begin
                    rf_wr_en_d   = 1'b1;
                    rf_wr_data_d = rx_data;
                    state_d      = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (rx_valid) begin
                    rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
                    rf_rd_en_d = 1'b1;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Read data rides in the high half so SEND_HI alone returns it.
                if (rf_rd_valid) begin
                    res_d[2*DATA_WIDTH-1:DATA_WIDTH] = rf_rd_data;
                    state_d = S_SEND_HI;
                end
            end
            S_OP_A: begin
                if (rx_valid) begin
                    rf_addr_d    = '0;
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = S_OP_B;
                end
            end
            S_OP_B: begin
                if (rx_valid) begin
                    rf_addr_d    = ADDR_WIDTH'(1);
                    rf_wr_data_d = rx_data;
                    rf_wr_en_d   = 1'b1;
                    state_d      = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (rx_valid) begin
                    alu_fun_d = rx_data[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (alu_out_valid) begin
                    res_d   = alu_out;
                    state_d = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                tx_data_d = res_q[DATA_WIDTH-1:0];
                if (!fifo_full) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!fifo_full) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Gate follows the registered state so it is high exactly while the ALU phase is live.
        cg_d = (state_d inside {S_OP_A, S_OP_B, S_ALU_FUN, S_ALU_WAIT});
    end

    assign rf_wr_en    = rf_wr_en_q;
    assign rf_rd_en    = rf_rd_en_q;
    assign rf_addr     = rf_addr_q;
    assign rf_wr_data  = rf_wr_data_q;
    assign alu_en      = alu_en_q;
    assign alu_fun     = alu_fun_q;
    assign clk_gate_en = cg_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Transaction-level bench: driver pushes expected rf/alu/tx events into queues,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_sys_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rf_wr_en, rf_rd_en;
    logic [3:0]  rf_addr;
    logic [7:0]  rf_wr_data;
    logic [7:0]  rf_rd_data;
    logic        rf_rd_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        fifo_full;

    logic        fifo_rand  = 1'b0;
    logic        fifo_force = 1'b0;
    logic        prev_full  = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_alu[$];
    logic [31:0] exp_tx[$];

    sys_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
        .clk_gate_en(clk_gate_en), .tx_data(tx_data), .tx_valid(tx_valid), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Full flag changes at +2 so it never races the driver's +1 updates.
    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            fifo_full = fifo_rand ? ($urandom_range(0, 2) == 0) : fifo_force;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rf_wr_en) begin
                chk("wr_pending", 32'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    logic [31:0] e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(rf_addr), {28'd0, e[11:8]});
                    chk("wr_data", 32'(rf_wr_data), {24'd0, e[7:0]});
                end
            end
            if (rf_rd_en) begin
                chk("rd_pending", 32'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("rd_addr", 32'(rf_addr), exp_rd.pop_front());
            end
            if (alu_en) begin
                chk("alu_pending", 32'(exp_alu.size() > 0), 1);
                chk("alu_cg", 32'(clk_gate_en), 1);
                if (exp_alu.size() > 0) chk("alu_fun", 32'(alu_fun), exp_alu.pop_front());
            end
            if (tx_valid) begin
                chk("tx_while_full", 32'(prev_full), 0);
                chk("tx_pending", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("tx_data", 32'(tx_data), exp_tx.pop_front());
            end
        end
        prev_full = fifo_full;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap(input bit rnd);
        if (rnd) step($urandom_range(0, 2));
    endtask

    task automatic wait_tx();
        for (int i = 0; i < 400 && exp_tx.size() != 0; i++) step(1);
        chk("tx_drain", 32'(exp_tx.size()), 0);
        exp_tx.delete();
    endtask

    // Waiting phase: optional stray bytes (must be dropped) and gate-level check.
    task automatic wait_phase(input bit rnd, input logic cg_exp);
        int n;
        n = rnd ? $urandom_range(0, 4) : 2;
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 1) == 1) send(8'($urandom));
            else step(1);
            chk("wait_cg", 32'(clk_gate_en), 32'(cg_exp));
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit rnd);
        exp_wr.push_back({20'd0, a[3:0], d});
        send(8'hAA); gap(rnd);
        send(a);     gap(rnd);
        send(d);
        chk("wr_cg_idle", 32'(clk_gate_en), 0);
        gap(rnd);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d, input bit rnd);
        exp_rd.push_back({28'd0, a[3:0]});
        send(8'hBB); gap(rnd);
        send(a);
        wait_phase(rnd, 1'b0);
        exp_tx.push_back({24'd0, d});
        rf_rd_data  = d;
        rf_rd_valid = 1'b1;
        step(1);
        rf_rd_valid = 1'b0;
        wait_tx();
        chk("rd_cg_idle", 32'(clk_gate_en), 0);
    endtask

    task automatic do_alu(input bit ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] f, input logic [15:0] res, input bit rnd);
        if (ops) begin
            exp_wr.push_back({20'd0, 4'd0, a});
            exp_wr.push_back({20'd0, 4'd1, b});
            send(8'hCC);
            chk("opa_cg", 32'(clk_gate_en), 1);
            gap(rnd); send(a); gap(rnd); send(b); gap(rnd);
        end else begin
            send(8'hDD);
            chk("fun_cg", 32'(clk_gate_en), 1);
            gap(rnd);
        end
        exp_alu.push_back({28'd0, f[3:0]});
        send(f);
        wait_phase(rnd, 1'b1);
        exp_tx.push_back({24'd0, res[7:0]});
        exp_tx.push_back({24'd0, res[15:8]});
        alu_out       = res;
        alu_out_valid = 1'b1;
        step(1);
        alu_out_valid = 1'b0;
        wait_tx();
        chk("alu_cg_idle", 32'(clk_gate_en), 0);
    endtask

    initial begin
        rst = 1'b0;
        rx_data = '0; rx_valid = 1'b0;
        rf_rd_data = '0; rf_rd_valid = 1'b0;
        alu_out = '0; alu_out_valid = 1'b0;
        #1;
        chk("reset_outs", 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                               clk_gate_en, tx_data, tx_valid}), 0);
        step(3);
        rst = 1'b1;
        step(1);

        // Directed cases.
        do_write(8'h05, 8'h3C, 1'b0);
        do_read(8'h02, 8'h7E, 1'b0);
        do_alu(1'b1, 8'h10, 8'h20, 8'h00, 16'h0030, 1'b0);

        // Result held while FIFO is full for 5 cycles.
        exp_alu.push_back(32'd1);
        send(8'hDD);
        send(8'h01);
        step(2);
        fifo_force = 1'b1;
        step(1);
        exp_tx.push_back(32'h34);
        exp_tx.push_back(32'h12);
        alu_out = 16'h1234; alu_out_valid = 1'b1;
        step(1);
        alu_out_valid = 1'b0;
        step(4);
        chk("full_hold", 32'(exp_tx.size()), 2);
        fifo_force = 1'b0;
        wait_tx();

        send(8'h55);
        chk("junk_cg", 32'(clk_gate_en), 0);
        do_write(8'hF1, 8'hFF, 1'b0);

        // Reset during ALU_WAIT aborts the command.
        exp_alu.push_back(32'd3);
        send(8'hDD);
        send(8'h03);
        step(3);
        rst = 1'b0;
        #1;
        chk("midrst_outs", 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                                clk_gate_en, tx_data, tx_valid}), 0);
        step(2);
        rst = 1'b1;
        alu_out = 16'hBEEF; alu_out_valid = 1'b1;
        step(1);
        alu_out_valid = 1'b0;
        step(10);
        chk("late_no_tx", 32'(exp_tx.size()), 0);
        do_write(8'h01, 8'hFF, 1'b0);

        // Randomized command stream with random FIFO back-pressure.
        fifo_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [7:0] j;
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom), 1'b1);
                1: do_read(8'($urandom), 8'($urandom), 1'b1);
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 1'b1);
                3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom), 1'b1);
                default: begin
                    j = 8'($urandom);
                    if (j == 8'hAA || j == 8'hBB || j == 8'hCC || j == 8'hDD) j = 8'h00;
                    send(j);
                    chk("junk_cg", 32'(clk_gate_en), 0);
                end
            endcase
        end
        fifo_rand = 1'b0;
        step(5);

        chk("wr_left",  32'(exp_wr.size()), 0);
        chk("rd_left",  32'(exp_rd.size()), 0);
        chk("alu_left", 32'(exp_alu.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
